imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the 512x32 instruction memory.
- Accepts a framed byte stream from a host over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words to consecutive word addresses starting at 0, then validates a checksum.
- Holds the processor in reset until a load completes with a good checksum.

Parameters:
- ADRS_W, 9, word-address width of the instruction memory.
- MAX_WORDS, 512, largest legal word count (2**ADRS_W).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  one-cycle memory write strobe.
- mem_adrs  out  ADRS_W  memory word address.
- mem_din  out  32  memory write data.
- cpu_rst  out  1  processor reset; high while the program is not valid.
- done  out  1  load finished, checksum good.
- err  out  1  load aborted (bad length or bad checksum).

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_adrs=0, mem_din=0, cpu_rst=1, done=0, err=0. Reset mid-load abandons the frame immediately; no further writes occur.
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready is a pure state decode: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise. in_valid gaps are legal anywhere.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes (MSB first per word), then one CSUM byte. CSUM must equal the XOR of all preceding frame bytes, including the length bytes.
- States and transitions:
  - IDLE: start -> LEN_HI. Running XOR, byte counter and word counter clear; done=0, err=0, cpu_rst=1.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte. If N==0 or N>MAX_WORDS -> ERR; else -> DATA.
  - DATA: shift each accepted byte into a 32-bit assembly register. On the 4th byte of a word, the next cycle drives mem_we=1, mem_adrs=word index, mem_din=assembled word. Word index increments after each write. After word N-1's 4th byte -> CSUM.
  - CSUM: accept byte. Match -> DONE; mismatch -> ERR.
  - DONE: done=1, cpu_rst=0. Held until start or rst.
  - ERR: err=1, cpu_rst=1. Held until start or rst.
- Latency: mem_we is asserted exactly one cycle after the edge that accepts a word's final byte. mem_adrs and mem_din are registered and hold their values after mem_we drops. done, err and cpu_rst update on the edge that accepts the CSUM byte (or LEN_LO, for a length error).
- The last data write (mem_we high) overlaps the first CSUM-state cycle. This is legal; the write still completes.
- start is ignored in LEN_HI..CSUM; a frame cannot be restarted except via rst. start in DONE or ERR reasserts cpu_rst and clears done/err on the same edge, entering LEN_HI.
- The word index never wraps: N ≤ MAX_WORDS guarantees a last address of at most MAX_WORDS-1.
- Data already written before an ERR stays in memory, but cpu_rst remains 1.

Test Plan:
- Good load, 2 words: start; bytes 00 02 3c 01 10 01 34 30 00 00 2a, in_valid continuous -> writes (adrs 0, 3c011001) then (adrs 1, 34300000), each one mem_we cycle; then done=1, cpu_rst=0, err=0.
- Same frame with final byte 2b -> both writes occur; err=1, done=0, cpu_rst=1. A subsequent start plus the good frame -> done=1.
- Length errors: bytes 00 00 -> err=1 on LEN_LO accept, in_ready=0, no mem_we. Bytes 02 01 (513) -> same response.
- Backpressure and idle: the good frame with random 0-5-cycle in_valid gaps produces identical writes and result. in_valid=1 in IDLE before start -> in_ready=0, nothing consumed.
- Reset mid-load: rst after 5 bytes of the good frame -> next cycle IDLE with all outputs at reset values, no mem_we. Later start plus a full frame loads correctly from adrs 0.
- Full size: N=512 (02 00), word k = k -> 512 writes, last at adrs 1FF with din 000001ff. With the correct checksum -> done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: framed big-endian byte stream -> 32-bit word writes,
// with XOR checksum validation gating the processor reset.
module imem_loader #(
  parameter int unsigned ADRS_W    = 9,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [31:0]       mem_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W   = ADRS_W + 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADRS_W-1:0] mem_adrs_q, mem_adrs_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept;
  logic [15:0]       len_word;
  logic              last_word;

  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA)   || (state_q == S_CSUM);
  end

  assign accept    = in_valid && in_ready;
  assign len_word  = {len_hi_q, in_data};
  assign last_word = (word_cnt_q == (len_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_adrs_q <= '0;
      mem_din_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      mem_we_q   <= mem_we_d;
      mem_adrs_q <= mem_adrs_d;
      mem_din_q  <= mem_din_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    csum_d     = csum_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    mem_we_d   = 1'b0;
    mem_adrs_d = mem_adrs_q;
    mem_din_d  = mem_din_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_rst_d  = cpu_rst_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          csum_d     = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_rst_d  = 1'b1;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          csum_d   = csum_q ^ in_data;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          len_d  = len_word[CNT_W-1:0];
          if ((len_word == '0) || (len_word > MAX_LEN)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = {asm_q[15:0], in_data};
          // The completed word bypasses asm_q so the write lands one cycle after its last byte.
          if (byte_cnt_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_adrs_d = word_cnt_q[ADRS_W-1:0];
            mem_din_d  = {asm_q, in_data};
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (last_word) begin
              state_d = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we   = mem_we_q;
  assign mem_adrs = mem_adrs_q;
  assign mem_din  = mem_din_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_rst  = cpu_rst_q;

endmodule
